// File: rtl/hazard_pkg.sv
// Shared constants for the load-use / branch hazard scoreboard: issue latencies,
// stall_cause bit positions and the countdown width helper.
package hazard_pkg;

  localparam int ALU_LAT_FWD      = 1;
  localparam int ALU_LAT_NOFWD    = 3;
  localparam int LOAD_EXTRA_FWD   = 1;
  localparam int LOAD_EXTRA_NOFWD = 2;

  localparam int CAUSE_RS = 0;
  localparam int CAUSE_RT = 1;

  // Widest value ever loaded is max(ALU no-forward, LOAD_LAT + 2).
  function automatic int cnt_width(input int load_lat);
    int maxv;
    maxv = (load_lat + LOAD_EXTRA_NOFWD > ALU_LAT_NOFWD) ? load_lat + LOAD_EXTRA_NOFWD
                                                         : ALU_LAT_NOFWD;
    return $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One per-register countdown: cycles until the register value is visible to an
// ID-stage consumer. A load overrides the running decrement.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdowns decide whether the
// instruction in ID must stall (freeze IF/ID, bubble into ID/EX).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic          id_branch,
  input  logic [AW-1:0] id_dst,
  input  logic          id_wr_en,
  input  logic          id_load,
  input  logic          flush,
  output logic          stall,
  output logic          bubble,
  output logic [1:0]    stall_cause,
  output logic [31:0]   stall_count
);

  localparam int CW = cnt_width(LOAD_LAT);

  localparam logic [CW-1:0] ALU_VAL = (FWD_EN != 0) ? CW'(ALU_LAT_FWD) : CW'(ALU_LAT_NOFWD);
  localparam logic [CW-1:0] LD_VAL  = (FWD_EN != 0) ? CW'(LOAD_LAT + LOAD_EXTRA_FWD)
                                                    : CW'(LOAD_LAT + LOAD_EXTRA_NOFWD);
  // With forwarding, an EX/MEM result one cycle away is still usable by ALU consumers.
  localparam logic [CW-1:0] THR_ALU = (FWD_EN != 0) ? CW'(1) : CW'(0);

  if ($clog2(NREG) != AW) begin : g_bad_aw
    $error("hazard_scoreboard: $clog2(NREG) must equal AW");
  end
  if (LOAD_LAT < 1 || LOAD_LAT > 4) begin : g_bad_lat
    $error("hazard_scoreboard: LOAD_LAT must be in 1..4");
  end

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] thr;
  logic [CW-1:0] ld_val;
  logic          rs_haz;
  logic          rt_haz;
  logic          issue;
  logic [31:0]   stall_count_q;
  logic [31:0]   stall_count_d;

  assign cnt[0] = '0;

  always_comb begin
    thr    = id_branch ? '0 : THR_ALU;
    rs_haz = id_rs_used && (id_rs != '0) && (cnt[id_rs] > thr);
    rt_haz = id_rt_used && (id_rt != '0) && (cnt[id_rt] > thr);
    stall_cause           = '0;
    stall_cause[CAUSE_RS] = rs_haz;
    stall_cause[CAUSE_RT] = rt_haz;
  end

  assign stall  = id_valid && !flush && (stall_cause != 2'b00);
  assign bubble = stall;

  assign issue  = id_valid && !stall && !flush && id_wr_en && (id_dst != '0);
  assign ld_val = id_load ? LD_VAL : ALU_VAL;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry #(
      .CW(CW)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (issue && (id_dst == AW'(r))),
      .load_val_i(ld_val),
      .cnt_o     (cnt[r])
    );
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three parameterisations share one ID-stage stimulus;
// each scenario pushes expected stall length/cause and pops it when the instruction issues.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_branch, id_wr_en, id_load, flush;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        stall_v  [3];
  logic        bubble_v [3];
  logic [1:0]  cause_v  [3];
  logic [31:0] scnt_v   [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int       stalls;
    logic [1:0] cause;
  } exp_t;
  exp_t exp_q[$];

  hazard_scoreboard u_dut_f (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_branch(id_branch),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_load(id_load), .flush(flush),
    .stall(stall_v[0]), .bubble(bubble_v[0]), .stall_cause(cause_v[0]), .stall_count(scnt_v[0])
  );

  hazard_scoreboard #(.LOAD_LAT(1), .FWD_EN(0)) u_dut_nf1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_branch(id_branch),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_load(id_load), .flush(flush),
    .stall(stall_v[1]), .bubble(bubble_v[1]), .stall_cause(cause_v[1]), .stall_count(scnt_v[1])
  );

  hazard_scoreboard #(.LOAD_LAT(3), .FWD_EN(0)) u_dut_nf3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_branch(id_branch),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_load(id_load), .flush(flush),
    .stall(stall_v[2]), .bubble(bubble_v[2]), .stall_cause(cause_v[2]), .stall_count(scnt_v[2])
  );

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_branch = 0; id_dst = 0; id_wr_en = 0; id_load = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID and hold it until the selected DUT lets it issue.
  task automatic drive_instr(input int sel, input logic [4:0] rs, input logic [4:0] rt,
                             input logic rsu, input logic rtu, input logic br,
                             input logic [4:0] dst, input logic wr, input logic ld,
                             output int stalls, output logic [1:0] cause1, output logic bub1);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_branch = br; id_dst = dst; id_wr_en = wr; id_load = ld; flush = 0;
    stalls = 0; cause1 = 2'b00; bub1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall_v[sel]) break;
      if (stalls == 0) begin
        cause1 = cause_v[sel];
        bub1   = bubble_v[sel];
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++; if (stall_v[d] !== 1'b0) begin errors++; $display("FAIL reset_stall dut%0d got=%b exp=0", d, stall_v[d]); end
      checks++; if (bubble_v[d] !== 1'b0) begin errors++; $display("FAIL reset_bubble dut%0d got=%b exp=0", d, bubble_v[d]); end
      checks++; if (cause_v[d] !== 2'b00) begin errors++; $display("FAIL reset_cause dut%0d got=%b exp=00", d, cause_v[d]); end
      checks++; if (scnt_v[d] !== 32'd0) begin errors++; $display("FAIL reset_count dut%0d got=%0d exp=0", d, scnt_v[d]); end
    end
  endtask

  task automatic test_load_use();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 1, s, c, b);
    exp_q.push_back('{1, 2'b01});
    drive_instr(0, 5'd5, 5'd7, 1, 1, 0, 5'd6, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL load_use_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (c !== e.cause) begin errors++; $display("FAIL load_use_cause got=%b exp=%b", c, e.cause); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL load_use_bubble got=%b exp=1", b); end
    checks++; if (scnt_v[0] !== 32'd1) begin errors++; $display("FAIL load_use_count got=%0d exp=1", scnt_v[0]); end
  endtask

  task automatic test_branch();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 0, s, c, b);
    exp_q.push_back('{1, 2'b01});
    drive_instr(0, 5'd5, 5'd0, 1, 1, 1, 5'd0, 0, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL alu_branch_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (c !== e.cause) begin errors++; $display("FAIL alu_branch_cause got=%b exp=%b", c, e.cause); end
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 1, s, c, b);
    exp_q.push_back('{2, 2'b01});
    drive_instr(0, 5'd5, 5'd0, 1, 1, 1, 5'd0, 0, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL load_branch_stalls got=%0d exp=%0d", s, e.stalls); end
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 0, s, c, b);
    exp_q.push_back('{0, 2'b00});
    drive_instr(0, 5'd5, 5'd0, 1, 0, 0, 5'd6, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL alu_alu_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (scnt_v[0] !== 32'd3) begin errors++; $display("FAIL branch_count got=%0d exp=3", scnt_v[0]); end
  endtask

  task automatic test_nofwd();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(1, 5'd0, 5'd0, 0, 0, 0, 5'd3, 1, 0, s, c, b);
    exp_q.push_back('{3, 2'b10});
    drive_instr(1, 5'd0, 5'd3, 1, 1, 0, 5'd4, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL nofwd_alu_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (c !== e.cause) begin errors++; $display("FAIL nofwd_alu_cause got=%b exp=%b", c, e.cause); end
    drive_instr(2, 5'd0, 5'd0, 0, 0, 0, 5'd3, 1, 1, s, c, b);
    exp_q.push_back('{5, 2'b10});
    drive_instr(2, 5'd0, 5'd3, 1, 1, 0, 5'd4, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL nofwd_load3_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (c !== e.cause) begin errors++; $display("FAIL nofwd_load3_cause got=%b exp=%b", c, e.cause); end
    checks++; if (scnt_v[2] !== 32'd8) begin errors++; $display("FAIL nofwd_load3_count got=%0d exp=8", scnt_v[2]); end
  endtask

  task automatic test_flush();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd2, 1, 1, s, c, b);
    // Dependent add r10,r2 sits in ID while a taken branch flushes it.
    id_valid = 1; id_rs = 5'd2; id_rs_used = 1; id_dst = 5'd10; id_wr_en = 1; flush = 1;
    @(negedge clk);
    checks++; if (stall_v[0] !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_v[0]); end
    checks++; if (bubble_v[0] !== 1'b0) begin errors++; $display("FAIL flush_bubble got=%b exp=0", bubble_v[0]); end
    @(posedge clk);
    #1;
    clear_inputs();
    exp_q.push_back('{1, 2'b01});
    drive_instr(0, 5'd2, 5'd10, 1, 1, 1, 5'd0, 0, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL flush_remaining_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (c !== e.cause) begin errors++; $display("FAIL flush_no_issue_cause got=%b exp=%b", c, e.cause); end
  endtask

  task automatic test_waw();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd4, 1, 1, s, c, b);
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd4, 1, 0, s, c, b);
    exp_q.push_back('{0, 2'b00});
    drive_instr(0, 5'd4, 5'd0, 1, 0, 0, 5'd9, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL waw_fwd_stalls got=%0d exp=%0d", s, e.stalls); end
    do_reset();
    drive_instr(2, 5'd0, 5'd0, 0, 0, 0, 5'd4, 1, 1, s, c, b);
    drive_instr(2, 5'd0, 5'd0, 0, 0, 0, 5'd4, 1, 0, s, c, b);
    exp_q.push_back('{3, 2'b01});
    drive_instr(2, 5'd4, 5'd0, 1, 0, 0, 5'd9, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL waw_override_stalls got=%0d exp=%0d", s, e.stalls); end
    do_reset();
    drive_instr(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, s, c, b);
    exp_q.push_back('{0, 2'b00});
    drive_instr(1, 5'd0, 5'd0, 1, 1, 1, 5'd1, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL r0_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (scnt_v[1] !== 32'd0) begin errors++; $display("FAIL r0_count got=%0d exp=0", scnt_v[1]); end
  endtask

  task automatic test_both_sources();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(2, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 1, s, c, b);
    drive_instr(2, 5'd0, 5'd0, 0, 0, 0, 5'd8, 1, 0, s, c, b);
    exp_q.push_back('{4, 2'b11});
    drive_instr(2, 5'd7, 5'd8, 1, 1, 1, 5'd0, 0, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL both_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (c !== e.cause) begin errors++; $display("FAIL both_cause got=%b exp=%b", c, e.cause); end
  endtask

  task automatic test_reset_mid_stall();
    int s; logic [1:0] c; logic b; exp_t e;
    do_reset();
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 1, s, c, b);
    id_valid = 1; id_rs = 5'd5; id_rs_used = 1; id_branch = 1;
    @(negedge clk);
    checks++; if (stall_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall got=%b exp=1", stall_v[0]); end
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    checks++; if (stall_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b exp=0", stall_v[0]); end
    checks++; if (scnt_v[0] !== 32'd0) begin errors++; $display("FAIL midrst_count got=%0d exp=0", scnt_v[0]); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    drive_instr(0, 5'd0, 5'd0, 0, 0, 0, 5'd5, 1, 1, s, c, b);
    exp_q.push_back('{1, 2'b01});
    drive_instr(0, 5'd5, 5'd7, 1, 1, 0, 5'd6, 1, 0, s, c, b);
    e = exp_q.pop_front();
    checks++; if (s !== e.stalls) begin errors++; $display("FAIL midrst_after_stalls got=%0d exp=%0d", s, e.stalls); end
    checks++; if (scnt_v[0] !== 32'd1) begin errors++; $display("FAIL midrst_after_count got=%0d exp=1", scnt_v[0]); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_nofwd();
    test_flush();
    test_waw();
    test_both_sources();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
